// File: rtl/t5_pkg.sv
// Shared constants and FSM encoding for the barrel-hart fetch scheduler.
package t5_pkg;
  localparam int          HBITS     = 2;
  localparam int          NHART     = 1 << HBITS;
  localparam logic [29:0] RESET_VEC = 30'h0;

  typedef enum logic {IDLE, REQ} state_t;
endpackage

// File: rtl/t5_rr_arb.sv
// Combinational round-robin pick: first runnable hart after 'last', wrapping.
module t5_rr_arb #(
  parameter int NHART = 4,
  parameter int HBITS = 2
) (
  input  logic [NHART-1:0] i_mask,
  input  logic [HBITS-1:0] i_last,
  output logic [HBITS-1:0] o_grant,
  output logic             o_gvld
);
  logic [HBITS-1:0] w_idx;

  // Walk from farthest to nearest so the nearest runnable hart wins.
  always_comb begin
    o_grant = '0;
    o_gvld  = 1'b0;
    w_idx   = '0;
    for (int i = NHART; i >= 1; i--) begin
      w_idx = i_last + HBITS'(i);
      if (i_mask[w_idx]) begin
        o_grant = w_idx;
        o_gvld  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/t5_hart_sched.sv
// Per-hart PC file, round-robin fetch issue over a single-outstanding
// Wishbone classic bus, and redirect/squash handling for the decoder.
module t5_hart_sched
  import t5_pkg::*;
(
  input  logic             sclk,
  input  logic             srst,
  input  logic [NHART-1:0] hart_run,
  input  logic             sstall,
  input  logic             bra_vld,
  input  logic [HBITS-1:0] bra_hart,
  input  logic [29:0]      bra_tgt,
  input  logic             iwb_ack,
  output logic             iwb_cyc,
  output logic             iwb_stb,
  output logic [29:0]      iwb_adr,
  output logic [29:0]      fpc,
  output logic [HBITS-1:0] fhart,
  output logic             sena
);
  state_t           r_state, w_state_next;
  logic [29:0]      r_pc [NHART];
  logic [29:0]      w_pc_next [NHART];
  logic [HBITS-1:0] r_cur, r_last;
  logic [29:0]      r_adr;
  logic             r_kill;
  logic [HBITS-1:0] w_grant;
  logic             w_gvld;
  logic             w_ack, w_bra_cur, w_accept, w_issue;
  logic [29:0]      w_issue_adr;

  t5_rr_arb #(.NHART(NHART), .HBITS(HBITS)) u_arb (
    .i_mask (hart_run),
    .i_last (r_last),
    .o_grant(w_grant),
    .o_gvld (w_gvld)
  );

  assign w_ack     = (r_state == REQ) && iwb_ack;
  assign w_bra_cur = bra_vld && (bra_hart == r_cur);
  assign w_accept  = w_ack && !r_kill && !w_bra_cur;

  // Redirect has priority over the post-delivery increment.
  genvar gi;
  generate
    for (gi = 0; gi < NHART; gi++) begin : g_pc
      assign w_pc_next[gi] = (bra_vld && bra_hart == HBITS'(gi)) ? bra_tgt :
                             (w_accept && r_cur == HBITS'(gi))   ? r_pc[gi] + 30'd1 :
                             r_pc[gi];
    end
  endgenerate

  // Back-to-back reissue of the same hart must see the just-advanced PC,
  // but a same-cycle redirect is not forwarded (kill covers that case).
  assign w_issue_adr = (w_accept && w_grant == r_cur) ? r_pc[w_grant] + 30'd1
                                                       : r_pc[w_grant];

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gvld && !sstall) begin
          w_issue      = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (iwb_ack) begin
          if (w_gvld && !sstall) w_issue = 1'b1;
          else                   w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_last  <= HBITS'(NHART - 1);
      r_adr   <= '0;
      r_kill  <= 1'b0;
      for (int h = 0; h < NHART; h++) r_pc[h] <= RESET_VEC;
    end else begin
      r_state <= w_state_next;
      for (int h = 0; h < NHART; h++) r_pc[h] <= w_pc_next[h];
      if (w_issue) begin
        r_cur  <= w_grant;
        r_last <= w_grant;
        r_adr  <= w_issue_adr;
        r_kill <= bra_vld && (bra_hart == w_grant);
      end else if (w_ack) begin
        r_kill <= 1'b0;
      end else if (r_state == REQ && w_bra_cur) begin
        r_kill <= 1'b1;
      end
    end
  end

  assign iwb_stb = (r_state == REQ);
  assign iwb_cyc = iwb_stb;
  assign iwb_adr = r_adr;
  assign fpc     = r_adr;
  assign fhart   = r_cur;
  assign sena    = w_ack && !r_kill && !w_bra_cur;
endmodule

// File: tb/tb_t5_hart_sched.sv
// Directed bench: expected deliveries are queued ahead of each ack and
// compared against fhart/fpc/iwb_adr/sena when the ack is applied.
module tb_t5_hart_sched;
  logic        sclk = 1'b0;
  logic        srst;
  logic [3:0]  hart_run;
  logic        sstall;
  logic        bra_vld;
  logic [1:0]  bra_hart;
  logic [29:0] bra_tgt;
  logic        iwb_ack;
  logic        iwb_cyc, iwb_stb, sena;
  logic [29:0] iwb_adr, fpc;
  logic [1:0]  fhart;

  typedef struct {
    logic [1:0]  h;
    logic [29:0] pc;
    logic        sena;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  t5_hart_sched dut (
    .sclk(sclk), .srst(srst), .hart_run(hart_run), .sstall(sstall),
    .bra_vld(bra_vld), .bra_hart(bra_hart), .bra_tgt(bra_tgt),
    .iwb_ack(iwb_ack), .iwb_cyc(iwb_cyc), .iwb_stb(iwb_stb),
    .iwb_adr(iwb_adr), .fpc(fpc), .fhart(fhart), .sena(sena)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [1:0] h, input logic [29:0] pc, input logic s);
    exp_t e;
    e.h = h; e.pc = pc; e.sena = s;
    sb.push_back(e);
  endtask

  task automatic wait_stb();
    int n = 0;
    @(negedge sclk);
    while (iwb_stb !== 1'b1 && n < 20) begin
      @(negedge sclk);
      n++;
    end
    chk("stb_wait", {31'b0, iwb_stb}, 32'd1);
  endtask

  task automatic ack_one(input int dly, input logic b_en, input logic [1:0] b_h,
                         input logic [29:0] b_t);
    exp_t e;
    wait_stb();
    repeat (dly) @(negedge sclk);
    iwb_ack = 1'b1; bra_vld = b_en; bra_hart = b_h; bra_tgt = b_t;
    #1;
    if (sb.size() == 0) begin
      $display("FAIL sb_underflow: ack with no expected entry");
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
    $display("ack: fhart=%0d fpc=%0h adr=%0h sena=%b (exp %0d %0h %b)",
             fhart, fpc, iwb_adr, sena, e.h, e.pc, e.sena);
    chk("fhart", {30'b0, fhart}, {30'b0, e.h});
    chk("fpc", {2'b0, fpc}, {2'b0, e.pc});
    chk("iwb_adr", {2'b0, iwb_adr}, {2'b0, e.pc});
    chk("sena", {31'b0, sena}, {31'b0, e.sena});
    @(posedge sclk);
    #1;
    iwb_ack = 1'b0; bra_vld = 1'b0;
  endtask

  task automatic do_reset();
    srst = 1'b0;
    repeat (2) @(posedge sclk);
    #1 srst = 1'b1;
  endtask

  initial begin
    hart_run = 4'b0; sstall = 1'b0; bra_vld = 1'b0; bra_hart = 2'd0;
    bra_tgt = 30'd0; iwb_ack = 1'b0;
    do_reset();

    // reset state
    @(negedge sclk);
    chk("rst_stb", {31'b0, iwb_stb}, 32'd0);
    chk("rst_cyc", {31'b0, iwb_cyc}, 32'd0);
    chk("rst_adr", {2'b0, iwb_adr}, 32'd0);
    chk("rst_fhart", {30'b0, fhart}, 32'd0);
    chk("rst_sena", {31'b0, sena}, 32'd0);

    // single hart, ack one cycle after stb
    hart_run = 4'b0001;
    push(0, 0, 1); push(0, 1, 1); push(0, 2, 1);
    ack_one(1, 0, 0, 0);
    ack_one(1, 0, 0, 0);
    hart_run = 4'b0000;
    ack_one(1, 0, 0, 0);
    chk("idle_after_drop", {31'b0, iwb_stb}, 32'd0);

    // all harts, ack in same cycle, no dead cycle
    do_reset();
    hart_run = 4'b1111;
    push(0, 0, 1); push(1, 0, 1); push(2, 0, 1); push(3, 0, 1); push(0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      ack_one(0, 0, 0, 0);
      chk("b2b_stb", {31'b0, iwb_stb}, 32'd1);
      chk("b2b_cyc", {31'b0, iwb_cyc}, 32'd1);
    end
    hart_run = 4'b0000;
    ack_one(0, 0, 0, 0);

    // harts 1 and 3 alternate; hart 3 dropped mid-REQ
    hart_run = 4'b1010;
    push(1, 1, 1); push(3, 1, 1); push(1, 2, 1); push(3, 2, 1); push(1, 3, 1); push(1, 4, 1);
    ack_one(0, 0, 0, 0);
    ack_one(0, 0, 0, 0);
    ack_one(0, 0, 0, 0);
    hart_run = 4'b0010;
    ack_one(1, 0, 0, 0);
    ack_one(0, 0, 0, 0);
    hart_run = 4'b0000;
    ack_one(0, 0, 0, 0);

    // redirect of cur while waiting for ack -> squashed, then new target
    hart_run = 4'b0100;
    wait_stb();
    bra_vld = 1'b1; bra_hart = 2'd2; bra_tgt = 30'h100;
    #1 chk("sena_noack", {31'b0, sena}, 32'd0);
    @(posedge sclk);
    #1 bra_vld = 1'b0;
    push(2, 1, 0);
    ack_one(2, 0, 0, 0);
    push(2, 30'h100, 1);
    hart_run = 4'b0000;
    ack_one(0, 0, 0, 0);

    // redirect of cur in the ack cycle: squashed, PC takes target (no +1)
    hart_run = 4'b0100;
    wait_stb();
    hart_run = 4'b0000;
    push(2, 30'h101, 0);
    ack_one(0, 1, 2, 30'h200);
    hart_run = 4'b0100;
    push(2, 30'h200, 1);
    wait_stb();
    hart_run = 4'b0000;
    ack_one(0, 0, 0, 0);

    // redirect of another hart during an ack: both updates apply
    hart_run = 4'b0001;
    wait_stb();
    hart_run = 4'b0000;
    push(0, 2, 1);
    ack_one(0, 1, 3, 30'h300);
    hart_run = 4'b1001;
    push(3, 30'h300, 1); push(0, 3, 1);
    ack_one(0, 0, 0, 0);
    hart_run = 4'b0000;
    ack_one(0, 0, 0, 0);

    // redirect in IDLE on the same edge the hart is issued: old PC, killed
    hart_run = 4'b0010; bra_vld = 1'b1; bra_hart = 2'd1; bra_tgt = 30'h50;
    @(posedge sclk);
    #1 bra_vld = 1'b0;
    push(1, 5, 0); push(1, 30'h50, 1);
    ack_one(0, 0, 0, 0);
    hart_run = 4'b0000;
    ack_one(0, 0, 0, 0);

    // stall held in IDLE blocks issue; stall mid-REQ does not
    sstall = 1'b1; hart_run = 4'b1111;
    repeat (5) begin
      @(negedge sclk);
      chk("stall_idle_stb", {31'b0, iwb_stb}, 32'd0);
    end
    sstall = 1'b0;
    wait_stb();
    sstall = 1'b1;
    push(2, 30'h201, 1);
    ack_one(1, 0, 0, 0);
    chk("stall_after_ack", {31'b0, iwb_stb}, 32'd0);

    // async reset mid-REQ
    sstall = 1'b0;
    wait_stb();
    chk("pre_rst_adr", {2'b0, iwb_adr}, 32'h301);
    #2 srst = 1'b0;
    #1;
    chk("arst_stb", {31'b0, iwb_stb}, 32'd0);
    chk("arst_cyc", {31'b0, iwb_cyc}, 32'd0);
    chk("arst_adr", {2'b0, iwb_adr}, 32'd0);
    hart_run = 4'b0100;
    @(posedge sclk);
    #1 srst = 1'b1;
    push(2, 0, 1);
    wait_stb();
    hart_run = 4'b0000;
    ack_one(0, 0, 0, 0);

    chk("sb_left", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
